// File: rtl/decode_control_pipe.sv
// Decode control unit: opcode decode into a registered ID/EX control word, load-use hazard bubbles,
// external stall/flush and a saturating hazard-stall counter. Optional DECODE_ILLEGAL_OP_EN adds o_illegal.
module decode_control_pipe #(
  parameter int unsigned NB_OP  = 6,
  parameter int unsigned NB_REG = 5,
  parameter int unsigned NB_CNT = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [NB_OP-1:0]  i_opcode,
  input  logic [NB_OP-1:0]  i_funct,
  input  logic [NB_REG-1:0] i_rs,
  input  logic [NB_REG-1:0] i_rt,
  input  logic [NB_REG-1:0] i_rd,
  input  logic              i_stall_ext,
  input  logic              i_flush,
  output logic              o_valid,
  output logic              o_alu_src,
  output logic [1:0]        o_ext_mode,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_reg_write,
  output logic              o_mem_to_reg,
  output logic [NB_REG-1:0] o_wb_reg,
  output logic              o_hazard_stall,
  output logic [NB_CNT-1:0] o_stall_count
`ifdef DECODE_ILLEGAL_OP_EN
  ,
  output logic              o_illegal
`endif
);

  typedef enum logic [NB_OP-1:0] {
    OP_RTYPE = 'h00,
    OP_ADDI  = 'h08,
    OP_ANDI  = 'h0C,
    OP_ORI   = 'h0D,
    OP_LUI   = 'h0F,
    OP_LW    = 'h23,
    OP_SW    = 'h2B
  } opcode_e;

  typedef struct packed {
    logic              alu_src;
    logic [1:0]        ext_mode;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [NB_REG-1:0] wb_reg;
  } ctrl_t;

  ctrl_t             dec;
  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [NB_CNT-1:0] cnt_q;
  logic              reg_write_raw;
  logic              reads_rs;
  logic              reads_rt;
  logic              funct_unused;

  assign funct_unused = ^i_funct;

  always_comb begin
    dec           = '0;
    reg_write_raw = 1'b0;
    reads_rs      = 1'b0;
    reads_rt      = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        reg_write_raw = 1'b1;
        dec.wb_reg    = i_rd;
        reads_rs      = 1'b1;
        reads_rt      = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        reg_write_raw = 1'b1;
        dec.wb_reg    = i_rt;
        reads_rs      = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        dec.alu_src   = 1'b1;
        dec.ext_mode  = 2'b01;
        reg_write_raw = 1'b1;
        dec.wb_reg    = i_rt;
        reads_rs      = 1'b1;
      end
      OP_LUI: begin
        dec.alu_src   = 1'b1;
        dec.ext_mode  = 2'b10;
        reg_write_raw = 1'b1;
        dec.wb_reg    = i_rt;
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        reg_write_raw  = 1'b1;
        dec.wb_reg     = i_rt;
        reads_rs       = 1'b1;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.wb_reg    = i_rt;
        reads_rs      = 1'b1;
        reads_rt      = 1'b1;
      end
      default: ;
    endcase
    dec.reg_write = reg_write_raw & (dec.wb_reg != '0);
  end

  assign o_hazard_stall = i_valid & valid_q & ctrl_q.mem_read & (ctrl_q.wb_reg != '0) &
                          ((reads_rs & (ctrl_q.wb_reg == i_rs)) |
                           (reads_rt & (ctrl_q.wb_reg == i_rt)));

`ifdef DECODE_ILLEGAL_OP_EN
  logic op_known;
  logic illegal_q;
  // Every table entry either writes back or stores, before the r0 suppression.
  assign op_known  = reg_write_raw | dec.mem_write;
  assign o_illegal = illegal_q;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
`ifdef DECODE_ILLEGAL_OP_EN
      illegal_q <= 1'b0;
`endif
    end else if (i_flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (!i_stall_ext) begin
      if (o_hazard_stall) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + NB_CNT'(1);
        end
      end else begin
        ctrl_q <= i_valid ? dec : '0;
`ifdef DECODE_ILLEGAL_OP_EN
        valid_q   <= i_valid & op_known;
        illegal_q <= illegal_q | (i_valid & ~op_known);
`else
        valid_q <= i_valid;
`endif
      end
    end
  end

  assign o_valid       = valid_q;
  assign o_alu_src     = ctrl_q.alu_src;
  assign o_ext_mode    = ctrl_q.ext_mode;
  assign o_mem_read    = ctrl_q.mem_read;
  assign o_mem_write   = ctrl_q.mem_write;
  assign o_reg_write   = ctrl_q.reg_write;
  assign o_mem_to_reg  = ctrl_q.mem_to_reg;
  assign o_wb_reg      = ctrl_q.wb_reg;
  assign o_stall_count = cnt_q;

endmodule

// File: tb/tb_decode_control_pipe.sv
// Scoreboard bench for decode_control_pipe: a reference model pushes the expected ID/EX word per cycle,
// which is popped and compared after the clock edge. Define DECODE_ILLEGAL_OP_EN to cover o_illegal.
module tb_decode_control_pipe;
  localparam int NB_OP  = 6;
  localparam int NB_REG = 5;
  localparam int NB_CNT = 8;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] LUI  = 6'b001111;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_reset, i_valid, i_stall_ext, i_flush;
  logic [NB_OP-1:0]  i_opcode, i_funct;
  logic [NB_REG-1:0] i_rs, i_rt, i_rd;
  logic              o_valid, o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg;
  logic [1:0]        o_ext_mode;
  logic [NB_REG-1:0] o_wb_reg;
  logic              o_hazard_stall;
  logic [NB_CNT-1:0] o_stall_count;
`ifdef DECODE_ILLEGAL_OP_EN
  logic              o_illegal;
`endif

  decode_control_pipe #(.NB_OP(NB_OP), .NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_opcode(i_opcode), .i_funct(i_funct),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_stall_ext(i_stall_ext), .i_flush(i_flush),
    .o_valid(o_valid), .o_alu_src(o_alu_src), .o_ext_mode(o_ext_mode), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg),
    .o_wb_reg(o_wb_reg), .o_hazard_stall(o_hazard_stall), .o_stall_count(o_stall_count)
`ifdef DECODE_ILLEGAL_OP_EN
    , .o_illegal(o_illegal)
`endif
  );

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic [1:0] ext;
    logic       mr;
    logic       mw;
    logic       rw;
    logic       m2r;
    logic [4:0] wb;
    logic [7:0] cnt;
    logic       ill;
  } word_t;

  word_t m;
  word_t sb[$];
  int n_run  = 0;
  int n_fail = 0;

  function automatic word_t observe();
    word_t w;
    w.valid   = o_valid;
    w.alu_src = o_alu_src;
    w.ext     = o_ext_mode;
    w.mr      = o_mem_read;
    w.mw      = o_mem_write;
    w.rw      = o_reg_write;
    w.m2r     = o_mem_to_reg;
    w.wb      = o_wb_reg;
    w.cnt     = o_stall_count;
`ifdef DECODE_ILLEGAL_OP_EN
    w.ill     = o_illegal;
`else
    w.ill     = 1'b0;
`endif
    return w;
  endfunction

  // Reference decode table; valid/cnt/ill are filled in by the caller.
  function automatic word_t decode_ref(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                                       output logic rrs, output logic rrt, output logic known);
    word_t w = '0;
    rrs = 1'b0; rrt = 1'b0; known = 1'b1;
    case (op)
      R:    begin w.rw = 1; w.wb = rd; rrs = 1; rrt = 1; end
      ADDI: begin w.alu_src = 1; w.rw = 1; w.wb = rt; rrs = 1; end
      ANDI: begin w.alu_src = 1; w.ext = 2'b01; w.rw = 1; w.wb = rt; rrs = 1; end
      ORI:  begin w.alu_src = 1; w.ext = 2'b01; w.rw = 1; w.wb = rt; rrs = 1; end
      LUI:  begin w.alu_src = 1; w.ext = 2'b10; w.rw = 1; w.wb = rt; end
      LW:   begin w.alu_src = 1; w.mr = 1; w.rw = 1; w.m2r = 1; w.wb = rt; rrs = 1; end
      SW:   begin w.alu_src = 1; w.mw = 1; w.wb = rt; rrs = 1; rrt = 1; end
      default: known = 1'b0;
    endcase
    if (w.wb == 5'd0) w.rw = 1'b0;
    return w;
  endfunction

  task automatic step(input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic stall, input logic flush, input string name);
    word_t d, nxt, exp_w, got;
    logic rrs, rrt, known, haz;
    i_valid = v; i_opcode = op; i_funct = 6'h20; i_rs = rs; i_rt = rt; i_rd = rd;
    i_stall_ext = stall; i_flush = flush;
    #1;
    d   = decode_ref(op, rt, rd, rrs, rrt, known);
    haz = v & m.valid & m.mr & (m.wb != 5'd0) & ((rrs & (m.wb == rs)) | (rrt & (m.wb == rt)));
    n_run++;
    if (o_hazard_stall !== haz) begin
      n_fail++;
      $display("FAIL %s hazard: got %b expected %b", name, o_hazard_stall, haz);
    end
    nxt = m;
    if (flush) begin
      nxt = '0; nxt.cnt = m.cnt; nxt.ill = m.ill;
    end else if (stall) begin
      nxt = m;
    end else if (haz) begin
      nxt = '0; nxt.ill = m.ill;
      nxt.cnt = (m.cnt == 8'hFF) ? m.cnt : m.cnt + 8'd1;
    end else begin
      nxt = v ? d : '0;
      nxt.cnt = m.cnt;
`ifdef DECODE_ILLEGAL_OP_EN
      nxt.valid = v & known;
      nxt.ill   = m.ill | (v & ~known);
`else
      nxt.valid = v;
      nxt.ill   = 1'b0;
`endif
    end
    sb.push_back(nxt);
    m = nxt;
    @(posedge clk);
    #1;
    exp_w = sb.pop_front();
    got   = observe();
    n_run++;
    if (got !== exp_w) begin
      n_fail++;
      $display("FAIL %s word: got %h expected %h", name, got, exp_w);
    end
  endtask

  task automatic test_reset();
    i_reset = 1; i_valid = 1; i_opcode = ADDI; i_funct = 0; i_rs = 1; i_rt = 9; i_rd = 0;
    i_stall_ext = 0; i_flush = 0;
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if ({observe(), o_hazard_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", {observe(), o_hazard_stall});
    end
    @(negedge clk);
    i_reset = 0;
    m = '0;
    step(1, ADDI, 1, 9, 0, 0, 0, "reset_first_load");
    n_run++;
    if ({o_valid, o_alu_src, o_reg_write, o_wb_reg} !== {1'b1, 1'b1, 1'b1, 5'd9}) begin
      n_fail++;
      $display("FAIL reset_first_fields: got %b expected %b",
               {o_valid, o_alu_src, o_reg_write, o_wb_reg}, {1'b1, 1'b1, 1'b1, 5'd9});
    end
  endtask

  task automatic test_back_to_back();
    step(1, R, 1, 2, 3, 0, 0, "b2b_rtype");
    n_run++;
    if ({o_ext_mode, o_wb_reg} !== {2'b00, 5'd3}) begin
      n_fail++; $display("FAIL b2b_rtype_fields: got %b expected %b", {o_ext_mode, o_wb_reg}, {2'b00, 5'd3});
    end
    step(1, ANDI, 1, 4, 0, 0, 0, "b2b_andi");
    n_run++;
    if ({o_ext_mode, o_wb_reg} !== {2'b01, 5'd4}) begin
      n_fail++; $display("FAIL b2b_andi_fields: got %b expected %b", {o_ext_mode, o_wb_reg}, {2'b01, 5'd4});
    end
    step(1, LUI, 0, 5, 0, 0, 0, "b2b_lui");
    n_run++;
    if ({o_ext_mode, o_wb_reg} !== {2'b10, 5'd5}) begin
      n_fail++; $display("FAIL b2b_lui_fields: got %b expected %b", {o_ext_mode, o_wb_reg}, {2'b10, 5'd5});
    end
    step(1, ORI, 2, 6, 0, 0, 0, "b2b_ori");
    step(0, ADDI, 1, 8, 0, 0, 0, "b2b_invalid");
  endtask

  task automatic test_load_use();
    step(1, LW, 1, 7, 0, 0, 0, "lu_load");
    step(1, R, 7, 2, 8, 0, 0, "lu_bubble");
    n_run++;
    if ({o_valid, o_stall_count} !== {1'b0, 8'd1}) begin
      n_fail++; $display("FAIL lu_bubble_count: got %h expected %h", {o_valid, o_stall_count}, {1'b0, 8'd1});
    end
    step(1, R, 7, 2, 8, 0, 0, "lu_add_loads");
    n_run++;
    if ({o_valid, o_wb_reg, o_reg_write} !== {1'b1, 5'd8, 1'b1}) begin
      n_fail++; $display("FAIL lu_add_fields: got %b expected %b", {o_valid, o_wb_reg, o_reg_write}, {1'b1, 5'd8, 1'b1});
    end
  endtask

  task automatic test_no_hazard();
    step(1, LW, 1, 0, 0, 0, 0, "r0_load");
    n_run++;
    if ({o_mem_read, o_reg_write} !== 2'b10) begin
      n_fail++; $display("FAIL r0_load_rw: got %b expected 10", {o_mem_read, o_reg_write});
    end
    step(1, R, 0, 2, 3, 0, 0, "r0_add");
    step(1, LW, 1, 7, 0, 0, 0, "lui_load");
    step(1, LUI, 7, 7, 0, 0, 0, "lui_after_lw");
    n_run++;
    if ({o_valid, o_ext_mode, o_stall_count} !== {1'b1, 2'b10, 8'd1}) begin
      n_fail++; $display("FAIL lui_no_stall: got %h expected %h", {o_valid, o_ext_mode, o_stall_count}, {1'b1, 2'b10, 8'd1});
    end
    step(1, LW, 1, 9, 0, 0, 0, "sw_load");
    step(1, SW, 1, 9, 0, 0, 0, "sw_rt_bubble");
    step(1, SW, 1, 9, 0, 0, 0, "sw_loads");
    n_run++;
    if ({o_mem_write, o_reg_write, o_stall_count} !== {1'b1, 1'b0, 8'd2}) begin
      n_fail++; $display("FAIL sw_fields: got %h expected %h", {o_mem_write, o_reg_write, o_stall_count}, {1'b1, 1'b0, 8'd2});
    end
  endtask

  task automatic test_stall_flush();
    step(1, LW, 1, 7, 0, 0, 0, "st_load");
    for (int i = 0; i < 3; i++) begin
      step(1, R, 7, 2, 8, 1, 0, "st_hold");
      n_run++;
      if ({o_mem_read, o_wb_reg, o_stall_count} !== {1'b1, 5'd7, 8'd2}) begin
        n_fail++; $display("FAIL st_hold_fields: got %h expected %h", {o_mem_read, o_wb_reg, o_stall_count}, {1'b1, 5'd7, 8'd2});
      end
    end
    step(1, R, 7, 2, 8, 0, 0, "st_release_bubble");
    n_run++;
    if ({o_valid, o_stall_count} !== {1'b0, 8'd3}) begin
      n_fail++; $display("FAIL st_release_count: got %h expected %h", {o_valid, o_stall_count}, {1'b0, 8'd3});
    end
    step(1, R, 7, 2, 8, 0, 0, "st_add_loads");
    step(1, LW, 1, 6, 0, 0, 0, "fl_load");
    step(1, R, 6, 2, 8, 0, 1, "fl_hazard_flush");
    n_run++;
    if ({o_valid, o_stall_count} !== {1'b0, 8'd3}) begin
      n_fail++; $display("FAIL fl_count: got %h expected %h", {o_valid, o_stall_count}, {1'b0, 8'd3});
    end
    step(1, R, 6, 2, 8, 0, 0, "fl_add_loads");
  endtask

  task automatic test_unknown();
    step(1, 6'b111111, 1, 2, 3, 0, 0, "unk_op");
`ifdef DECODE_ILLEGAL_OP_EN
    n_run++;
    if ({o_valid, o_illegal} !== 2'b01) begin
      n_fail++; $display("FAIL unk_illegal: got %b expected 01", {o_valid, o_illegal});
    end
    step(1, ADDI, 1, 2, 0, 0, 0, "unk_sticky");
    n_run++;
    if (o_illegal !== 1'b1) begin
      n_fail++; $display("FAIL unk_sticky_flag: got %b expected 1", o_illegal);
    end
`else
    n_run++;
    if ({o_valid, o_reg_write, o_alu_src} !== 3'b100) begin
      n_fail++; $display("FAIL unk_zero_ctrl: got %b expected 100", {o_valid, o_reg_write, o_alu_src});
    end
`endif
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      step(1, LW, 1, 5, 0, 0, 0, "sat_load");
      step(1, R, 5, 1, 2, 0, 0, "sat_bubble");
    end
    n_run++;
    if (o_stall_count !== 8'hFF) begin
      n_fail++; $display("FAIL sat_count: got %h expected ff", o_stall_count);
    end
  endtask

  task automatic test_reset_mid();
    step(1, LW, 1, 3, 0, 0, 0, "mid_load");
    i_valid = 1; i_opcode = R; i_rs = 3; i_rt = 1; i_rd = 2;
    #2;
    i_reset = 1;
    #1;
    n_run++;
    if ({observe(), o_hazard_stall} !== '0) begin
      n_fail++; $display("FAIL mid_reset_clear: got %h expected 0", {observe(), o_hazard_stall});
    end
    @(negedge clk);
    i_reset = 0;
    m = '0;
    step(1, ADDI, 1, 4, 0, 0, 0, "mid_after_reset");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_no_hazard();
    test_stall_flush();
    test_unknown();
    test_saturate();
    test_reset_mid();
    n_run++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
